// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, LSB-first, one operand bit per clock.
// A request is a single-cycle start_i sample (together with sub_i, a_i, b_i)
// taken while the unit is in IDLE or DONE. busy_o is high for the WIDTH
// cycles of SHIFT. done_o is high for exactly one cycle, during which sum_o
// and ovf_o already hold the new result. start_i seen in that DONE cycle
// begins the next operation back-to-back. Operands need only be valid on
// the start edge.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH:0]   sum_o,
  output logic             ovf_o,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counter value while the most significant operand bit is being processed.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sa_q;
  logic [WIDTH-1:0]   sb_q;
  logic [WIDTH-2:0]   r_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic               sub_q;
  logic [WIDTH:0]     sum_q;
  logic               ovf_q;
  logic               busy_q;
  logic               done_q;

  logic               load;
  logic               step;
  logic               last;
  logic               fa_bit;
  logic               fa_carry;
  logic               c_msb_in;
  logic [WIDTH-1:0]   r_next;

  // Next-state and control decode for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        step = 1'b1;
        if (cnt_q == LAST_CNT) begin
          last    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // One-bit full adder on the current LSBs; the carry feeding the MSB is
  // kept as c_msb_in so overflow is the XOR of carry into and out of the MSB.
  always_comb begin
    fa_bit   = sa_q[0] ^ sb_q[0] ^ carry_q;
    fa_carry = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
    c_msb_in = carry_q;
    // The result bits collected so far plus the bit being produced now;
    // after the final step this is the complete WIDTH-bit result.
    r_next   = {fa_bit, r_q};
  end

  // State register and registered status flags.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_SHIFT);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // Operand shift registers, carry flop, mode and bit counter.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      sa_q    <= '0;
      sb_q    <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (load) begin
      sa_q    <= a_i;
      // Subtraction is A + ~B + 1: B is inverted here and the +1 enters as
      // the initial carry.
      sb_q    <= sub_i ? ~b_i : b_i;
      carry_q <= sub_i;
      sub_q   <= sub_i;
      cnt_q   <= '0;
    end else if (step) begin
      sa_q    <= {1'b0, sa_q[WIDTH-1:1]};
      sb_q    <= {1'b0, sb_q[WIDTH-1:1]};
      carry_q <= fa_carry;
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // Result register: each new sum bit enters at the MSB and moves right.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= '0;
    end else if (step) begin
      r_q <= r_next[WIDTH-1:1];
    end
  end

  // Published result; updated only on the edge that processes the MSB and
  // held until the next operation completes.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else if (last) begin
      // In subtract mode the top bit is the borrow, i.e. inverted carry-out.
      sum_q <= {(sub_q ? ~fa_carry : fa_carry), r_next};
      ovf_q <= c_msb_in ^ fa_carry;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign sum_o       = sum_q;
  assign ovf_o       = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised bit-serial adder/subtractor, LSB-first, one bit per clock. Successor to the fixed 8-bit serial adder, generalised in operand width and adding a subtract mode. Also adds a start/busy/done handshake and carry, borrow and signed-overflow reporting. Sits beside the existing shift-register and full-adder datapath blocks as a self-contained arithmetic unit, with its control FSM internal to the module.

Parameters:
WIDTH, 8, operand width in bits (legal range 2..64).
CNT_W, $clog2(WIDTH+1), bit-counter width (derived, do not override).

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
start_i  input  1  request; sampled only in IDLE or DONE
sub_i  input  1  0 = A+B, 1 = A-B; sampled with start_i
a_i  input  WIDTH  operand A; sampled with start_i
b_i  input  WIDTH  operand B; sampled with start_i
busy_o  output  1  high while in SHIFT
done_o  output  1  one-cycle pulse when the result is valid
sum_o  output  WIDTH+1  result; see arithmetic rules
ovf_o  output  1  signed (two's complement) overflow of the last operation

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state goes to IDLE.
  - busy_o, done_o, ovf_o go to 0; sum_o goes to 0.
  - Operand shift registers, counter and carry flop are cleared.
- Reset has priority over all other inputs.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start_i=1 at edge E0 loads A into shift register SA and B' into SB.
  - B' = b_i when sub_i=0; B' = ~b_i when sub_i=1.
  - Carry flop is loaded with sub_i. Counter is cleared. Next state is SHIFT.
  - start_i=0: remain in IDLE.
- SHIFT, at each edge E1..E_WIDTH:
  - bit = SA[0]^SB[0]^c.
  - Carry updates to the majority of (SA[0], SB[0], c).
  - SA and SB shift right by one.
  - bit is shifted into the MSB of result register R (WIDTH bits).
  - Counter increments.
- Before the final bit is processed (counter = WIDTH-1), the current carry c is captured as c_msb_in.
- The edge that processes the final bit (E_WIDTH) also:
  - registers sum_o and ovf_o;
  - moves the state to DONE.
- start_i is ignored in SHIFT; operand inputs may change freely once E0 has passed.
- DONE lasts one cycle; done_o = 1 in this cycle.
  - start_i=1 here is accepted exactly as in IDLE (next state SHIFT).
  - Otherwise next state is IDLE.
- Throughput: one operation every WIDTH+1 cycles.
- Latency: done_o is high in the cycle after edge E_WIDTH, i.e. WIDTH cycles after the start edge.
- busy_o = (state==SHIFT), registered.
- Arithmetic, add (sub_i=0): sum_o = {carry_out, R}, the unsigned sum (range 0..2^(WIDTH+1)-2).
- Arithmetic, sub (sub_i=1):
  - sum_o[WIDTH-1:0] = (A-B) mod 2^WIDTH.
  - sum_o[WIDTH] = ~carry_out, the borrow: 1 iff A<B unsigned.
- ovf_o = c_msb_in ^ carry_out in both modes.
- sum_o and ovf_o hold their values until the next operation completes or reset.
- Reset mid-SHIFT: the operation is aborted with no done_o pulse, and sum_o is cleared to 0.
- start_i held high continuously: one operation every WIDTH+1 cycles, operands sampled in each DONE cycle.

Test Plan:
- WIDTH=8, add 0xFF+0x01, start at E0 -> busy_o high for 8 cycles; done_o pulse at cycle 8; sum_o=0x100, ovf_o=0.
- WIDTH=8, sub 0x05-0x07 -> sum_o=0x1FE (borrow=1, low byte 0xFE), ovf_o=0.
- WIDTH=8, add 0x7F+0x01 -> sum_o=0x080, ovf_o=1.
- WIDTH=8, sub 0x80-0x01 -> sum_o=0x07F, ovf_o=1.
- WIDTH=8, change a_i/b_i and pulse start_i during SHIFT -> result unaffected; one done_o only.
- WIDTH=8, rst_n=0 at SHIFT cycle 4 -> no done_o; all outputs 0; a new start afterwards completes normally.
- WIDTH=16, start_i held high, ops 0xFFFF+0xFFFF then 0x0000-0x0001 -> sum_o=0x1FFFE then 0x1FFFF; done_o pulses 17 cycles apart.
